// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq_if
// Brief    : Request/response and shared-ALU signals of the MULTU/DIVU sequencer
// Revision : 1.0
// ============================================================================
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cont;
  logic             alu_nez;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Core/ALU side: issues requests, supplies the ALU result, reads status and HI/LO
  modport master (
    output start, op, src_a, src_b, alu_result,
    input  alu_a, alu_b, alu_cont, alu_nez, busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, alu_result,
    output alu_a, alu_b, alu_cont, alu_nez, busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Brief    : Iterative MULTU/DIVU, one shared-ALU add/sub per cycle, HI/LO out
// Revision : 1.0
// ============================================================================
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  alu_muldiv_seq_if.slave bus
);

  localparam int                 c_cnt_w   = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
  localparam logic [2:0]         c_alu_add = 3'b010;
  localparam logic [2:0]         c_alu_sub = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_opd;    // multiplicand M / divisor D
  logic [WIDTH-1:0]   r_acc;    // P_hi / remainder R
  logic [WIDTH-1:0]   r_low;    // P_lo / quotient Q
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [c_cnt_w-1:0] r_count;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_x;
  logic               w_carry;
  logic               w_borrow;
  logic               w_take;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_low_nxt;

  assign w_x = {r_acc[WIDTH-2:0], r_low[WIDTH-1]};

  // The ALU has no carry/borrow out, so the MSB terms are rebuilt from the operand MSBs
  assign w_carry  = (r_acc[WIDTH-1] & r_opd[WIDTH-1]) |
                    ((r_acc[WIDTH-1] | r_opd[WIDTH-1]) & ~bus.alu_result[WIDTH-1]);
  assign w_borrow = (~w_x[WIDTH-1] & r_opd[WIDTH-1]) |
                    (~(w_x[WIDTH-1] ^ r_opd[WIDTH-1]) & bus.alu_result[WIDTH-1]);
  assign w_take   = r_acc[WIDTH-1] | ~w_borrow;

  assign bus.alu_a    = (r_state == S_MUL) ? r_acc :
                        (r_state == S_DIV) ? w_x   : '0;
  assign bus.alu_b    = ((r_state == S_MUL) || (r_state == S_DIV)) ? r_opd : '0;
  assign bus.alu_cont = (r_state == S_DIV) ? c_alu_sub : c_alu_add;
  assign bus.alu_nez  = 1'b0;

  always_comb begin
    w_acc_nxt = r_acc;
    w_low_nxt = r_low;
    case (r_state)
      S_MUL: begin
        if (r_low[0]) begin
          w_acc_nxt = {w_carry, bus.alu_result[WIDTH-1:1]};
          w_low_nxt = {bus.alu_result[0], r_low[WIDTH-1:1]};
        end else begin
          w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
          w_low_nxt = {r_acc[0], r_low[WIDTH-1:1]};
        end
      end
      S_DIV: begin
        if (w_take) begin
          w_acc_nxt = bus.alu_result;
          w_low_nxt = {r_low[WIDTH-2:0], 1'b1};
        end else begin
          w_acc_nxt = w_x;
          w_low_nxt = {r_low[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_opd   <= '0;
      r_acc   <= '0;
      r_low   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (!bus.op) begin
              r_opd   <= bus.src_a;
              r_acc   <= '0;
              r_low   <= bus.src_b;
              r_count <= c_last;
              r_busy  <= 1'b1;
              r_state <= S_MUL;
            end else if (bus.src_b != '0) begin
              r_opd   <= bus.src_b;
              r_acc   <= '0;
              r_low   <= bus.src_a;
              r_count <= c_last;
              r_busy  <= 1'b1;
              r_state <= S_DIV;
            end else begin
              // Divide by zero: fixed result, no iteration
              r_hi    <= bus.src_a;
              r_lo    <= '1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_acc   <= w_acc_nxt;
          r_low   <= w_low_nxt;
          r_count <= r_count - 1'b1;
          if (r_count == '0) begin
            r_hi    <= w_acc_nxt;
            r_lo    <= w_low_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Brief    : Directed MULTU/DIVU vectors checked against an arithmetic model
// Revision : 1.0
// ============================================================================
module tb_alu_muldiv_seq;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_muldiv_seq_if #(.WIDTH(32)) bus ();

  // Shared 32-bit ALU
  assign bus.alu_result = (bus.alu_cont == 3'b110) ? (bus.alu_a - bus.alu_b)
                                                   : (bus.alu_a + bus.alu_b);

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 iterating, 2 done
  int          m_phase = 0;
  int          m_iter  = 0;
  logic        m_op    = 1'b0;
  logic [31:0] m_a     = '0;
  logic [31:0] m_b     = '0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_iter  = 0;
      m_hi    = '0;
      m_lo    = '0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
             m_op = bus.op;
             m_a  = bus.src_a;
             m_b  = bus.src_b;
             if (bus.op && bus.src_b == 32'd0) begin
               m_hi    = bus.src_a;
               m_lo    = 32'hFFFF_FFFF;
               m_phase = 2;
             end else begin
               m_iter  = 0;
               m_phase = 1;
             end
           end
        1: begin
             m_iter++;
             if (m_iter == 32) begin
               if (m_op) begin
                 m_hi = m_a % m_b;
                 m_lo = m_a / m_b;
               end else begin
                 {m_hi, m_lo} = 64'(m_a) * 64'(m_b);
               end
               m_phase = 2;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // After k iterations the multiply accumulator holds a*(b mod 2^k) >> k, and the
  // divide remainder is the top k dividend bits mod b
  always @(negedge clk) begin : cmp
    logic [63:0] pm;
    logic [63:0] r;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [2:0]  ec;
    if (!reset) begin
      ea = '0;
      eb = '0;
      ec = 3'b010;
      if (m_phase == 1) begin
        if (!m_op) begin
          pm = 64'(m_a) * (64'(m_b) & ((64'd1 << m_iter) - 64'd1));
          ea = 32'(pm >> m_iter);
          eb = m_a;
        end else begin
          r  = (64'(m_a) >> (32 - m_iter)) % 64'(m_b);
          ea = 32'({r[62:0], m_a[31 - m_iter]});
          eb = m_b;
          ec = 3'b110;
        end
      end
      chk("busy",     64'(bus.busy),     64'(m_phase == 1));
      chk("done",     64'(bus.done),     64'(m_phase == 2));
      chk("hi",       64'(bus.hi),       64'(m_hi));
      chk("lo",       64'(bus.lo),       64'(m_lo));
      chk("alu_a",    64'(bus.alu_a),    64'(ea));
      chk("alu_b",    64'(bus.alu_b),    64'(eb));
      chk("alu_cont", 64'(bus.alu_cont), 64'(ec));
      chk("alu_nez",  64'(bus.alu_nez),  64'd0);
    end
  end

  // Issue one request; latency counts cycles from the start cycle to the done cycle
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int elat,
                        input int inject_at, input string name);
    int n     = 0;
    int nbusy = 0;
    bit seen  = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == inject_at) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) nbusy++;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk({name, " done_seen"}, 64'(seen), 64'd1);
    chk({name, " latency"},   64'(n),     64'(elat));
    chk({name, " busy_cyc"},  64'(nbusy), 64'(elat - 1));
    chk({name, " hi"},        64'(bus.hi), 64'(eh));
    chk({name, " lo"},        64'(bus.lo), 64'(el));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) @(negedge clk);
    chk("rst busy",     64'(bus.busy),     64'd0);
    chk("rst done",     64'(bus.done),     64'd0);
    chk("rst hi",       64'(bus.hi),       64'd0);
    chk("rst lo",       64'(bus.lo),       64'd0);
    chk("rst alu_a",    64'(bus.alu_a),    64'd0);
    chk("rst alu_cont", 64'(bus.alu_cont), 64'd2);
    reset = 1'b0;

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0, "mul_max");
    run_op(1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 33, 0, "mul_shift");
    run_op(1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        33, 0, "div_100_7");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         33, 0, "div_borrow");
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 33, 0, "div_by_one");
    run_op(1'b0, 32'd3,         32'd4,         32'd0,         32'd12,        33, 10, "mul_ignore_start");
    run_op(1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1,  0, "div_by_zero");

    // Request during the DONE cycle must be dropped
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.src_a = 32'd9;
    bus.src_b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_start done", 64'(bus.done), 64'd0);
    chk("done_start hi",   64'(bus.hi),   64'd5);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.src_a = 32'hDEAD_BEEF;
    bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst busy",     64'(bus.busy),     64'd0);
    chk("arst done",     64'(bus.done),     64'd0);
    chk("arst hi",       64'(bus.hi),       64'd0);
    chk("arst lo",       64'(bus.lo),       64'd0);
    chk("arst alu_a",    64'(bus.alu_a),    64'd0);
    chk("arst alu_b",    64'(bus.alu_b),    64'd0);
    chk("arst alu_cont", 64'(bus.alu_cont), 64'd2);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 33, 0, "mul_after_reset");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
